// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: FSM encodings,
// fetch-queue payload and fetch constants.
package if_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam int unsigned FQ_DEPTH  = 2;
    localparam int unsigned CNT_W     = $clog2(FQ_DEPTH + 1);

    typedef enum logic [1:0] {
        S_READY   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcadd;
    } fq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_queue.sv
// Two-entry fetch FIFO of {instruction, fetch PC + 4}; slot0 is always the head.
module if_fetch_stage_fetch_queue
    import if_fetch_stage_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fq_entry_t        wdata,
    output fq_entry_t        head,
    output logic [CNT_W-1:0] count
);

    fq_entry_t        slot0;
    fq_entry_t        slot1;
    logic [CNT_W-1:0] cnt;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt < CNT_W'(FQ_DEPTH)) || pop_ok);

    // Flush dominates push and pop.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == '0) begin
                        slot0 <= wdata;
                    end else begin
                        slot1 <= wdata;
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - CNT_W'(1);
                end
                2'b11: begin
                    if (cnt == CNT_W'(1)) begin
                        slot0 <= wdata;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= wdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = slot0;
    assign count = cnt;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM, fetch queue
// feeding IF/ID, stall and branch/jump redirect handling.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_INSTR,
    parameter int unsigned QDEPTH   = FQ_DEPTH
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        In_Stall,
    input  logic        In_BranchTaken,
    input  logic [31:0] In_BranchTarget,
    input  logic        In_Jump,
    input  logic [31:0] In_JumpTarget,
    output logic        Out_IMemReq,
    output logic [31:0] Out_IMemAddr,
    input  logic        In_IMemReady,
    input  logic        In_IMemValid,
    input  logic [31:0] In_IMemData,
    output logic [31:0] Out_Instruction,
    output logic [31:0] Out_PCAdder,
    output logic        Out_Valid,
    output logic        Out_IFIDEnable
);

    fetch_state_e     state;
    fetch_state_e     state_nxt;
    logic [31:0]      pc;
    logic [31:0]      pc_nxt;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             resp;
    logic             head_valid;
    logic             q_push;
    logic             q_pop;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   occ_after;
    fq_entry_t        q_head;
    fq_entry_t        q_wdata;
    logic             req_c;
    logic             accept;

    assign redirect    = In_BranchTaken | In_Jump;
    assign redirect_pc = word_align(In_BranchTaken ? In_BranchTarget : In_JumpTarget);
    assign head_valid  = (q_count != '0);
    assign resp        = In_IMemValid && (state != S_READY);
    assign q_push      = In_IMemValid && (state == S_WAIT);
    assign q_pop       = head_valid && !In_Stall;

    // While a kept request is outstanding the PC already points one word past it.
    assign q_wdata   = '{instr: In_IMemData, pcadd: pc};
    assign occ_after = (CNT_W + 1)'(q_count) + (CNT_W + 1)'(q_push) - (CNT_W + 1)'(q_pop);

    if_fetch_stage_fetch_queue u_fetch_queue (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .push    (q_push),
        .pop     (q_pop),
        .flush   (redirect),
        .wdata   (q_wdata),
        .head    (q_head),
        .count   (q_count)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_READY;
            pc    <= word_align(RESET_PC);
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Request only when the memory slot frees up and the queue has room for the answer.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_c     = Reset_n && !redirect && ((state == S_READY) || resp)
                    && ((32'(occ_after) + 32'd1) <= QDEPTH);
        accept    = req_c && In_IMemReady;

        case (state)
            S_READY: begin
                if (accept) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT, S_DISCARD: begin
                if (In_IMemValid) begin
                    state_nxt = accept ? S_WAIT : S_READY;
                end
            end
            default: begin
                state_nxt = S_READY;
            end
        endcase

        if (accept) begin
            pc_nxt = pc + PC_STEP;
        end

        // Accept is impossible during a redirect, so S_WAIT here means still outstanding.
        if (redirect) begin
            pc_nxt = redirect_pc;
            if (state_nxt == S_WAIT) begin
                state_nxt = S_DISCARD;
            end
        end
    end

    assign Out_IMemReq     = req_c;
    assign Out_IMemAddr    = pc;
    assign Out_Valid       = head_valid;
    assign Out_Instruction = head_valid ? q_head.instr : NOP_WORD;
    assign Out_PCAdder     = head_valid ? q_head.pcadd : 32'h0000_0000;
    assign Out_IFIDEnable  = ~In_Stall;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small latency-programmable memory responder.
module tb_if_fetch_stage;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        In_Stall;
    logic        In_BranchTaken;
    logic [31:0] In_BranchTarget;
    logic        In_Jump;
    logic [31:0] In_JumpTarget;
    logic        Out_IMemReq;
    logic [31:0] Out_IMemAddr;
    logic        In_IMemReady;
    logic        In_IMemValid;
    logic [31:0] In_IMemData;
    logic [31:0] Out_Instruction;
    logic [31:0] Out_PCAdder;
    logic        Out_Valid;
    logic        Out_IFIDEnable;

    int          compared   = 0;
    int          mismatched = 0;
    int          lat        = 1;
    int          rem        = 0;
    logic [31:0] paddr      = 32'h0;

    if_fetch_stage dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .In_Stall        (In_Stall),
        .In_BranchTaken  (In_BranchTaken),
        .In_BranchTarget (In_BranchTarget),
        .In_Jump         (In_Jump),
        .In_JumpTarget   (In_JumpTarget),
        .Out_IMemReq     (Out_IMemReq),
        .Out_IMemAddr    (Out_IMemAddr),
        .In_IMemReady    (In_IMemReady),
        .In_IMemValid    (In_IMemValid),
        .In_IMemData     (In_IMemData),
        .Out_Instruction (Out_Instruction),
        .Out_PCAdder     (Out_PCAdder),
        .Out_Valid       (Out_Valid),
        .Out_IFIDEnable  (Out_IFIDEnable)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: answers an accepted request 'lat' cycles later; keeps counting through reset.
    initial begin : responder
        In_IMemValid = 1'b0;
        In_IMemData  = 32'h0;
        forever begin
            @(negedge Clock);
            In_IMemValid = 1'b0;
            if (rem > 0) begin
                rem = rem - 1;
                if (rem == 0) begin
                    In_IMemValid = 1'b1;
                    In_IMemData  = mem_word(paddr);
                end
            end
            #1;
            if (Reset_n && Out_IMemReq && In_IMemReady) begin
                paddr = Out_IMemAddr;
                rem   = lat;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, 32'(Out_IMemReq), 32'(req));
        chk({tag, ".addr"}, Out_IMemAddr, addr);
    endtask

    task automatic chk_head(input string tag, input logic valid, input logic [31:0] pcadd);
        chk({tag, ".valid"}, 32'(Out_Valid), 32'(valid));
        if (valid) begin
            chk({tag, ".pcadd"}, Out_PCAdder, pcadd);
            chk({tag, ".instr"}, Out_Instruction, mem_word(pcadd - 32'd4));
        end else begin
            chk({tag, ".pcadd"}, Out_PCAdder, 32'h0);
            chk({tag, ".instr"}, Out_Instruction, 32'h0);
        end
    endtask

    task automatic cyc(input logic rst_v, input logic stall, input logic ready,
                       input logic br, input logic [31:0] bt,
                       input logic jmp, input logic [31:0] jt);
        @(negedge Clock);
        Reset_n         = rst_v;
        In_Stall        = stall;
        In_IMemReady    = ready;
        In_BranchTaken  = br;
        In_BranchTarget = bt;
        In_Jump         = jmp;
        In_JumpTarget   = jt;
        #2;
    endtask

    task automatic run(input logic stall, input logic ready);
        cyc(1'b1, stall, ready, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin : stimulus
        Reset_n         = 1'b0;
        In_Stall        = 1'b0;
        In_IMemReady    = 1'b1;
        In_BranchTaken  = 1'b0;
        In_BranchTarget = 32'h0;
        In_Jump         = 1'b0;
        In_JumpTarget   = 32'h0;

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_req("rst", 1'b0, 32'h0);
        chk_head("rst", 1'b0, 32'h0);

        // Zero-wait streaming
        run(1'b0, 1'b1); chk_req("zw0", 1'b1, 32'd0);  chk_head("zw0", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("zw1", 1'b1, 32'd4);  chk_head("zw1", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("zw2", 1'b1, 32'd8);  chk_head("zw2", 1'b1, 32'd4);
        run(1'b0, 1'b1); chk_req("zw3", 1'b1, 32'd12); chk_head("zw3", 1'b1, 32'd8);
        run(1'b0, 1'b1); chk_req("zw4", 1'b1, 32'd16); chk_head("zw4", 1'b1, 32'd12);

        // Stall for four cycles, then release
        run(1'b1, 1'b1); chk_req("st0", 1'b0, 32'd20); chk_head("st0", 1'b1, 32'd16);
        chk("st0.en", 32'(Out_IFIDEnable), 32'd0);
        run(1'b1, 1'b1); chk_req("st1", 1'b0, 32'd20); chk_head("st1", 1'b1, 32'd16);
        run(1'b1, 1'b1); chk_req("st2", 1'b0, 32'd20); chk_head("st2", 1'b1, 32'd16);
        run(1'b1, 1'b1); chk_req("st3", 1'b0, 32'd20); chk_head("st3", 1'b1, 32'd16);
        run(1'b0, 1'b1); chk_req("st4", 1'b1, 32'd20); chk_head("st4", 1'b1, 32'd16);
        chk("st4.en", 32'(Out_IFIDEnable), 32'd1);
        run(1'b0, 1'b1); chk_req("st5", 1'b1, 32'd24); chk_head("st5", 1'b1, 32'd20);
        run(1'b0, 1'b1); chk_req("st6", 1'b1, 32'd28); chk_head("st6", 1'b1, 32'd24);

        // Memory not ready for three cycles
        run(1'b0, 1'b0); chk_req("nr0", 1'b1, 32'd32); chk_head("nr0", 1'b1, 32'd28);
        run(1'b0, 1'b0); chk_req("nr1", 1'b1, 32'd32); chk_head("nr1", 1'b1, 32'd32);
        run(1'b0, 1'b0); chk_req("nr2", 1'b1, 32'd32); chk_head("nr2", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("nr3", 1'b1, 32'd32); chk_head("nr3", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("nr4", 1'b1, 32'd36); chk_head("nr4", 1'b0, 32'd0);
        lat = 3;
        run(1'b0, 1'b1); chk_req("nr5", 1'b1, 32'd40); chk_head("nr5", 1'b1, 32'd36);

        // Reset with a request outstanding; its late response must be ignored
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_req("mr0", 1'b0, 32'd0); chk_head("mr0", 1'b0, 32'd0);
        run(1'b0, 1'b0); chk_req("mr1", 1'b1, 32'd0); chk_head("mr1", 1'b0, 32'd0);
        run(1'b0, 1'b0); chk_req("mr2", 1'b1, 32'd0); chk_head("mr2", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("mr3", 1'b1, 32'd0); chk_head("mr3", 1'b0, 32'd0);

        // Branch while a slow request is outstanding
        run(1'b0, 1'b1); chk_req("br0", 1'b0, 32'd4); chk_head("br0", 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
        chk_req("br1", 1'b0, 32'd4); chk_head("br1", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("br2", 1'b1, 32'h100); chk_head("br2", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("br3", 1'b0, 32'h104); chk_head("br3", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("br4", 1'b0, 32'h104); chk_head("br4", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("br5", 1'b1, 32'h104); chk_head("br5", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("br6", 1'b0, 32'h108); chk_head("br6", 1'b1, 32'h104);
        lat = 1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_req("br7", 1'b0, 32'd0); chk_head("br7", 1'b0, 32'd0);

        // Branch and jump together; misaligned jump target
        run(1'b0, 1'b1); chk_req("bj0", 1'b1, 32'd0); chk_head("bj0", 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
        chk_req("bj1", 1'b0, 32'd4); chk_head("bj1", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("bj2", 1'b1, 32'h40); chk_head("bj2", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("bj3", 1'b1, 32'h44); chk_head("bj3", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("bj4", 1'b1, 32'h48); chk_head("bj4", 1'b1, 32'h44);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h43);
        chk_req("ja0", 1'b0, 32'h4C); chk_head("ja0", 1'b1, 32'h48);
        run(1'b0, 1'b1); chk_req("ja1", 1'b1, 32'h40); chk_head("ja1", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("ja2", 1'b1, 32'h44); chk_head("ja2", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("ja3", 1'b1, 32'h48); chk_head("ja3", 1'b1, 32'h44);

        // PC wrap at the top of the address space
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        chk_req("wr0", 1'b0, 32'h4C); chk_head("wr0", 1'b1, 32'h48);
        run(1'b0, 1'b1); chk_req("wr1", 1'b1, 32'hFFFF_FFFC); chk_head("wr1", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("wr2", 1'b1, 32'h0); chk_head("wr2", 1'b0, 32'd0);
        run(1'b0, 1'b1); chk_req("wr3", 1'b1, 32'h4); chk_head("wr3", 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
